// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, default width.
package md_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } md_state_t;

endpackage

// File: rtl/md_sign_fix.sv
// Two-lane conditional two's-complement negate: takes magnitudes of operands or restores result signs.
// Purely combinational, no latency, no flow control.
module md_sign_fix #(
    parameter int WX = 32,
    parameter int WY = 32
) (
    input  logic [WX-1:0] x,
    input  logic          neg_x,
    input  logic [WY-1:0] y,
    input  logic          neg_y,
    output logic [WX-1:0] rx,
    output logic [WY-1:0] ry
);

    assign rx = neg_x ? (~x + WX'(1)) : x;
    assign ry = neg_y ? (~y + WY'(1)) : y;

endmodule

// File: rtl/md_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO; WIDTH+1 cycles start-to-done, one cycle for divide by zero.
// No queueing: start is ignored while busy, flush aborts without touching HI/LO.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t          state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div_r;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] acc;

    logic               is_div_in;
    logic               signed_in;
    logic               neg_a_in;
    logic               neg_b_in;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    assign is_div_in = (op == MD_DIV) || (op == MD_DIVU);
    assign signed_in = (op == MD_MULT) || (op == MD_DIV);
    assign neg_a_in  = signed_in & a[WIDTH-1];
    assign neg_b_in  = signed_in & b[WIDTH-1];

    md_sign_fix #(.WX(WIDTH), .WY(WIDTH)) u_abs (
        .x     (a),
        .neg_x (neg_a_in),
        .y     (b),
        .neg_y (neg_b_in),
        .rx    (mag_a),
        .ry    (mag_b)
    );

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc[WIDTH-1:0] shifts dividend bits out and quotient bits in.
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   rem_nxt;

    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        shifted = {rem, acc[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        acc_nxt = acc;
        rem_nxt = rem;
        if (is_div_r) begin
            acc_nxt = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~diff[WIDTH]};
            rem_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        end else begin
            acc_nxt = acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
        end
    end

    // Sign correction works on the post-step values so HI/LO are valid in the same cycle as done.
    logic [2*WIDTH-1:0] x_in;
    logic [2*WIDTH-1:0] res_x;
    logic [WIDTH-1:0]   res_y;

    assign x_in = is_div_r ? {{WIDTH{1'b0}}, acc_nxt[WIDTH-1:0]} : acc_nxt;

    md_sign_fix #(.WX(2*WIDTH), .WY(WIDTH)) u_fix (
        .x     (x_in),
        .neg_x (neg_a ^ neg_b),
        .y     (rem_nxt),
        .neg_y (neg_a),
        .rx    (res_x),
        .ry    (res_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            is_div_r    <= 1'b0;
            neg_a       <= 1'b0;
            neg_b       <= 1'b0;
            opnd        <= '0;
            rem         <= '0;
            acc         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        is_div_r    <= is_div_in;
                        neg_a       <= neg_a_in;
                        neg_b       <= neg_b_in;
                        cnt         <= '0;
                        rem         <= '0;
                        opnd        <= is_div_in ? mag_b : mag_a;
                        acc         <= {{WIDTH{1'b0}}, (is_div_in ? mag_a : mag_b)};
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        if (is_div_in && (b == '0)) begin
                            state       <= ST_DONE;
                            done        <= 1'b1;
                            hi          <= a;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= ST_CALC;
                        end
                    end else if (!start) begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc <= acc_nxt;
                        rem <= rem_nxt;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WIDTH-1)) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            hi    <= is_div_r ? res_y : res_x[2*WIDTH-1:WIDTH];
                            lo    <= res_x[WIDTH-1:0];
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: arithmetic reference model feeds a queue, a negedge monitor checks every done.
module tb_md_unit;
    import md_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    md_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           due;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero, remainder follows dividend.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input int n);
        exp_t        e;
        longint      sx, sy, q, r;
        logic [63:0] p;
        e.dbz = 1'b0;
        e.due = n + W;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            MD_MULT: begin
                p = 64'(sx * sy);
                {e.hi, e.lo} = p;
            end
            MD_MULTU: begin
                p = {32'b0, x} * {32'b0, y};
                {e.hi, e.lo} = p;
            end
            default: begin
                if (y == 0) begin
                    e.hi  = x;
                    e.lo  = '1;
                    e.dbz = 1'b1;
                    e.due = n;
                end else if (o == MD_DIV) begin
                    q = sx / sy;
                    r = sx % sy;
                    e.lo = q[W-1:0];
                    e.hi = r[W-1:0];
                end else begin
                    e.lo = x / y;
                    e.hi = x % y;
                end
            end
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d want no done", cyc);
            end else begin
                me = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(me.due));
                chk("hi", 64'(hi), 64'(me.hi));
                chk("lo", 64'(lo), 64'(me.lo));
                chk("div_by_zero", 64'(div_by_zero), 64'(me.dbz));
            end
        end
    end

    // Returns at the negedge after the sampling edge, so cyc equals that edge's index.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit expect_done);
        @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        if (expect_done) sb.push_back(model(o, x, y, cyc + 1));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (busy === 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (busy !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: got busy=%b want 0 within 100 cycles", busy);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            4:       return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        logic [1:0] ro;
        logic [W-1:0] ra, rb;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        flush = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;

        // MULTU latency and HI/LO stability during CALC
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
        n = cyc;
        chk("busy_after_start", 64'(busy), 64'd1);
        repeat (10) @(negedge clk);
        chk("hi_stable_calc", 64'(hi), 64'd0);
        chk("busy_mid_calc", 64'(busy), 64'd1);
        wait_idle();
        chk("busy_drop_cycle", 64'(cyc), 64'(n + W + 1));

        issue(MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
        wait_idle();
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_idle();
        issue(MD_DIVU, 32'd100, 32'd7, 1'b1);
        wait_idle();
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_idle();

        // Divide by zero: one-cycle result, sticky flag until the next start
        issue(MD_DIVU, 32'd123, 32'd0, 1'b1);
        wait_idle();
        chk("dbz_sticky", 64'(div_by_zero), 64'd1);
        issue(MD_MULTU, 32'd3, 32'd4, 1'b1);
        chk("dbz_cleared", 64'(div_by_zero), 64'd0);
        wait_idle();

        // Flush mid-CALC: no done, HI/LO keep 3*4
        issue(MD_MULTU, 32'd5, 32'd5, 1'b0);
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_hi", 64'(hi), 64'd0);
        chk("flush_lo", 64'(lo), 64'd12);
        repeat (40) @(negedge clk);
        issue(MD_MULTU, 32'd5, 32'd5, 1'b1);
        wait_idle();

        // Async reset mid-CALC
        issue(MD_MULT, 32'h1234_5678, 32'h8765_4321, 1'b0);
        repeat (13) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // MT writes: ignored while busy, applied in IDLE
        issue(MD_MULTU, 32'd6, 32'd7, 1'b1);
        hi_we = 1'b1;
        wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        hi_we = 1'b0;
        wait_idle();
        chk("mthi_busy_ignored", 64'(hi), 64'd0);
        hi_we = 1'b1;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_idle", 64'(hi), 64'hA5A5_A5A5);
        chk("mthi_lo_kept", 64'(lo), 64'd42);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        chk("mt_both_hi", 64'(hi), 64'h1234_5678);
        chk("mt_both_lo", 64'(lo), 64'h1234_5678);

        // Random operations; a stray start while busy must be ignored
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            issue(ro, ra, rb, 1'b1);
            if (busy === 1'b1 && ($urandom_range(0, 1) == 1)) begin
                start = 1'b1;
                op    = 2'($urandom_range(0, 3));
                a     = $urandom;
                b     = $urandom;
                @(negedge clk);
                start = 1'b0;
            end
            wait_idle();
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
